// File: rtl/addfloat_seq_pkg.sv
// Shared definitions for the addfloat_seq feeder: FSM encoding, data width
// and the constant operand the addfloat method adds to every input.
package addfloat_seq_pkg;

  localparam int ADDF_DATA_W = 32;

  // addfloat returns i_run_input_a_0 + 1.3f
  localparam logic [ADDF_DATA_W-1:0] ADDF_CONST_A = 32'h3fa66666;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_OUT     = 3'd4
  } seq_state_e;

endpackage

// File: rtl/addfloat_seq_fifo.sv
// Synchronous operand FIFO for addfloat_seq. The head entry is visible on
// o_data without a read strobe so the sequencer can register it in the same
// cycle it pops. Pushes while full and pops while empty are ignored.
module addfloat_seq_fifo
  import addfloat_seq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = ADDF_DATA_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_data,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage array: written on push, never reset
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/addfloat_seq.sv
// addfloat_seq: buffers float operands, issues them one at a time to the
// single-shot addfloat block over its run-request/busy handshake, and returns
// each result on a valid/ready stream.
// Optional feature: define ADDFLOAT_SEQ_TIMEOUT_EN to abandon a transaction
// after TIMEOUT enabled cycles of waiting and raise a sticky o_err.
module addfloat_seq
  import addfloat_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ce,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [ADDF_DATA_W-1:0] s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [ADDF_DATA_W-1:0] m_data,
  output logic                   o_run_req,
  output logic [ADDF_DATA_W-1:0] o_run_input_a_0,
  input  logic                   i_run_busy,
  input  logic [ADDF_DATA_W-1:0] i_run_return,
  output logic                   o_err,
  output logic                   o_idle
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("addfloat_seq: DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("addfloat_seq: TIMEOUT must be at least 1");
  end

  seq_state_e             r_state;
  logic                   r_run_req;
  logic [ADDF_DATA_W-1:0] r_run_a;
  logic                   r_m_valid;
  logic [ADDF_DATA_W-1:0] r_m_data;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_start;
  logic                   w_full;
  logic                   w_empty;
  logic [ADDF_DATA_W-1:0] w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_tmo_fire;

  // A new transaction needs a queued operand and an adder that is not still
  // finishing a request issued before a reset.
  assign w_start = (r_state == ST_IDLE) && !w_empty && !i_run_busy;
  assign w_push  = s_valid && s_ready && ce;
  assign w_pop   = w_start && ce;

  assign s_ready         = !w_full;
  assign o_idle          = (w_count == '0) && (r_state == ST_IDLE) && !r_m_valid;
  assign o_run_req       = r_run_req;
  assign o_run_input_a_0 = r_run_a;
  assign m_valid         = r_m_valid;
  assign m_data          = r_m_data;

  addfloat_seq_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ADDF_DATA_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (s_data),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

`ifdef ADDFLOAT_SEQ_TIMEOUT_EN
  localparam int                TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE  = 1;

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err;

  // Give up only when the wait would otherwise continue; a handshake that
  // completes on the last allowed cycle still delivers its result.
  assign w_tmo_fire = ce && (r_tmo_cnt == TMO_LAST) &&
                      (((r_state == ST_WAIT_HI) && !i_run_busy) ||
                       ((r_state == ST_WAIT_LO) &&  i_run_busy));
  assign o_err = r_err;

  // Wait-cycle counter: cleared when REQ hands over to WAIT_HI
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tmo_cnt <= '0;
    end else if (ce) begin
      if (r_state == ST_REQ) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == ST_WAIT_HI) || (r_state == ST_WAIT_LO)) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
      end
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_tmo_fire) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_tmo_fire = 1'b0;
  assign o_err      = 1'b0;
`endif

  // Sequencer FSM: pop, one-cycle request, wait for busy high then low, present
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_run_req <= 1'b0;
      r_run_a   <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (ce) begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_run_a   <= w_head;
            r_run_req <= 1'b1;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_run_req <= 1'b0;
          r_state   <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (i_run_busy) begin
            r_state <= ST_WAIT_LO;
          end else if (w_tmo_fire) begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT_LO: begin
          // The adder settles its return a cycle before dropping busy
          if (!i_run_busy) begin
            r_m_data  <= i_run_return;
            r_m_valid <= 1'b1;
            r_state   <= ST_OUT;
          end else if (w_tmo_fire) begin
            r_state <= ST_IDLE;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addfloat_seq.sv
// Bench for addfloat_seq: a behavioural addfloat stand-in (busy for 10
// enabled cycles, return settled one cycle before busy falls) plus a
// reference scoreboard that computes a + 1.3f with real arithmetic.
module tb_addfloat_seq;
  import addfloat_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ce;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = 32'h0;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        o_run_req;
  logic [31:0] o_run_input_a_0;
  logic        o_err;
  logic        o_idle;

  // stimulus controls
  int          ce_mode  = 0;     // 0: always on, 1: alternate, 2: random
  logic        ce_var   = 1'b1;
  bit          mr_rand  = 1'b0;
  logic        mr_force = 1'b1;
  logic        mr_rnd   = 1'b1;
  bit          stuck    = 1'b0;

  // adder model state
  logic        busy_m = 1'b0;
  logic [31:0] ret_m  = 32'h0;
  logic [31:0] pend   = 32'h0;
  int          acnt   = 0;

  // scoreboard / counters
  logic [31:0] exp_q[$];
  logic [31:0] out_q[$];
  int          n_out = 0;
  int          n_req = 0;
  int          n_overlap = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  assign ce      = (ce_mode == 0) ? 1'b1 : ce_var;
  assign m_ready = mr_rand ? mr_rnd : mr_force;

  always #5 clock = ~clock;

  addfloat_seq #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TMO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .ce              (ce),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .o_run_req       (o_run_req),
    .o_run_input_a_0 (o_run_input_a_0),
    .i_run_busy      (busy_m),
    .i_run_return    (ret_m),
    .o_err           (o_err),
    .o_idle          (o_idle)
  );

  // ---------------- reference arithmetic ----------------
  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) m = real'(b[22:0]) * (2.0 ** (-149));
    else        m = real'({1'b1, b[22:0]}) * (2.0 ** (e - 150));
    return b[31] ? -m : m;
  endfunction

  // Round a double to single precision, nearest-even (normal range only)
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [30:0] mag;
    int          e;
    if (r == 0.0) return 32'h0;
    d   = $realtobits(r);
    e   = int'(d[62:52]) - 1023 + 127;
    mag = {e[7:0], d[51:29]};
    if (d[28] && ((|d[27:0]) || d[29])) mag = mag + 31'd1;
    return {d[63], mag};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a);
    return r2f(f2r(a) + f2r(ADDF_CONST_A));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- environment processes ----------------
  // Clock-enable and m_ready pattern, updated just after each edge
  always @(posedge clock) begin
    #1;
    case (ce_mode)
      1:       ce_var = ~ce_var;
      2:       ce_var = ($urandom_range(0, 9) < 7);
      default: ce_var = 1'b1;
    endcase
    mr_rnd = ($urandom_range(0, 3) != 0);
  end

  // addfloat stand-in, gated by the same ce; not affected by the DUT reset
  always @(posedge clock) begin
    if (ce) begin
      if (!busy_m) begin
        if (o_run_req && !stuck) begin
          busy_m <= 1'b1;
          acnt   <= 10;
          pend   <= ref_add(o_run_input_a_0);
          ret_m  <= ~ref_add(o_run_input_a_0);
        end
      end else begin
        acnt <= acnt - 1;
        if (acnt == 2) ret_m  <= pend;
        if (acnt == 1) busy_m <= 1'b0;
      end
    end
  end

  // Scoreboard and protocol monitor, sampled mid-cycle
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (s_valid && s_ready && ce) exp_q.push_back(ref_add(s_data));
      if (m_valid && m_ready && ce) begin
        out_q.push_back(m_data);
        n_out++;
        if (exp_q.size() == 0) check_eq("sb_unexpected", m_data, 32'hx);
        else                   check_eq("sb_data", m_data, exp_q.pop_front());
      end
      if (o_run_req && ce) n_req++;
      if (o_run_req && busy_m) n_overlap++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_op(input logic [31:0] d);
    bit acc;
    acc     = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int t = 0; t < 400 && !acc; t++) begin
      @(negedge clock);
      acc = s_ready && ce && !reset;
      @(posedge clock);
      #1;
    end
    s_valid = 1'b0;
    if (!acc) check_eq("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_mvalid(input int limit, output int cyc);
    cyc = 0;
    while (!m_valid && cyc < limit) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    if (!m_valid) check_eq("mvalid_timeout", 32'd0, 32'd1);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int          lat;
    int          r0;
    int          base;
    int          n0;
    int          k;
    bit          stable;
    logic [31:0] md;
    logic [31:0] op;
    logic [31:0] burst [4];
    logic [31:0] bres  [4];

    burst = '{32'h3f800000, 32'h40000000, 32'h00000000, 32'hbfa66666};
    bres  = '{32'h40133333, 32'h40533333, 32'h3fa66666, 32'h00000000};

    step(3);
    reset = 1'b0;

    // reset state
    check_eq("rst_run_req", 32'(o_run_req), 32'd0);
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_data", m_data, 32'h0);
    check_eq("rst_run_a", o_run_input_a_0, 32'h0);
    check_eq("rst_err", 32'(o_err), 32'd0);
    check_eq("rst_s_ready", 32'(s_ready), 32'd1);
    check_eq("rst_idle", 32'(o_idle), 32'd1);

    // single operand, 13-cycle latency, one request pulse
    r0 = n_req;
    push_op(32'h3f800000);
    wait_mvalid(100, lat);
    check_eq("single_latency", lat, 32'd13);
    check_eq("single_data", m_data, 32'h40133333);
    check_eq("single_run_a", o_run_input_a_0, 32'h3f800000);
    check_eq("single_req_pulses", n_req - r0, 32'd1);
    step(1);
    check_eq("single_consumed", 32'(m_valid), 32'd0);

    // back-pressure: hold m_ready low while the FIFO fills behind OUT
    mr_force = 1'b0;
    push_op(32'h3f800000);
    wait_mvalid(100, lat);
    for (int i = 0; i < 4; i++) push_op(burst[i]);
    check_eq("full_s_ready", 32'(s_ready), 32'd0);
    r0     = n_req;
    md     = m_data;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (m_data !== md || !m_valid) stable = 1'b0;
    end
    check_eq("hold_stable", 32'(stable), 32'd1);
    check_eq("hold_data", m_data, 32'h40133333);
    check_eq("hold_no_req", n_req - r0, 32'd0);
    base     = out_q.size();
    mr_force = 1'b1;
    for (int t = 0; t < 1000 && out_q.size() < base + 5; t++) step(1);
    check_eq("burst_count", out_q.size() - base, 32'd5);
    if (out_q.size() >= base + 5) begin
      for (int i = 0; i < 4; i++) check_eq($sformatf("burst_res%0d", i), out_q[base + 1 + i], bres[i]);
    end

    // clock enable alternating every cycle doubles the latency
    for (int t = 0; t < 100 && !o_idle; t++) step(1);
    ce_mode = 1;
    push_op(32'h40000000);
    wait_mvalid(200, lat);
    check_eq("ce_latency", lat, 32'd26);
    check_eq("ce_data", m_data, 32'h40533333);
    for (int t = 0; t < 10 && m_valid; t++) step(1);
    ce_mode = 0;
    step(2);

    // randomized operands, random ce and m_ready, checked by scoreboard
    ce_mode = 2;
    mr_rand = 1'b1;
    n0      = n_out;
    for (int i = 0; i < 24; i++) begin
      op[31]    = 1'($urandom_range(0, 1));
      op[30:23] = 8'($urandom_range(115, 139));
      op[22:0]  = 23'($urandom);
      push_op(op);
      step($urandom_range(0, 3));
    end
    for (int t = 0; t < 8000 && !(n_out == n0 + 24 && o_idle); t++) step(1);
    check_eq("rand_count", n_out - n0, 32'd24);
    ce_mode  = 0;
    mr_rand  = 1'b0;
    mr_force = 1'b1;
    step(2);

    // reset while waiting for busy to fall, two operands still queued
    push_op(32'h3f800000);
    push_op(32'h40000000);
    push_op(32'h00000000);
    for (int t = 0; t < 50 && !busy_m; t++) step(1);
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_eq("midrst_idle", 32'(o_idle), 32'd1);
    check_eq("midrst_m_valid", 32'(m_valid), 32'd0);
    check_eq("midrst_s_ready", 32'(s_ready), 32'd1);
    push_op(32'hbfa66666);
    wait_mvalid(100, lat);
    check_eq("midrst_next_data", m_data, 32'h00000000);
    step(2);

`ifdef ADDFLOAT_SEQ_TIMEOUT_EN
    // adder never answers: sticky error after TMO wait cycles, no result
    stuck = 1'b1;
    n0    = n_out;
    push_op(32'h3f800000);
    for (int t = 0; t < 20 && !o_run_req; t++) step(1);
    k = 0;
    while (!o_err && k < 200) begin
      step(1);
      k++;
    end
    check_eq("tmo_cycles", k, TMO + 1);
    step(3);
    check_eq("tmo_no_result", n_out - n0, 32'd0);
    check_eq("tmo_idle", 32'(o_idle), 32'd1);
    check_eq("tmo_sticky", 32'(o_err), 32'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    stuck = 1'b0;
    check_eq("tmo_err_cleared", 32'(o_err), 32'd0);
`else
    k = 0;
`endif

    step(5);
    check_eq("no_req_while_busy", n_overlap, 32'd0);
    check_eq("sb_drained", exp_q.size(), 32'd0);
    check_eq("final_err", 32'(o_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/addfloat_seq.md
# addfloat_seq

Upstream feeder and result collector for the `addfloat` method block. It buffers incoming 32-bit IEEE-754 single-precision operands in a small FIFO and issues them one at a time over the `addfloat` run-request/busy protocol. It captures each `o_run_return` and presents it on a valid/ready output stream. This lets a streaming producer use the single-shot adder without tracking busy timing.

## Interface
- `DEPTH`, 4: operand FIFO entries; power of two, ≥2.
- `TIMEOUT`, 64: maximum cycles to wait for the adder; used only with the timeout feature.

- `clock` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `ce` in 1: clock enable; when low every register holds.
- `s_valid` in 1: operand valid.
- `s_ready` out 1: `!full`.
- `s_data` in 32: operand bit pattern.
- `m_valid` out 1: result valid.
- `m_ready` in 1: result accepted.
- `m_data` out 32: adder return value.
- `o_run_req` out 1: to adder `i_run_req`.
- `o_run_input_a_0` out 32: to adder `i_run_input_a_0`.
- `i_run_busy` in 1: from adder `o_run_busy`.
- `i_run_return` in 32: from adder `o_run_return`.
- `o_err` out 1: sticky timeout flag.
- `o_idle` out 1: FIFO empty, FSM in IDLE, `m_valid` low.

## Operation
- **FIFO:**
  - Push when `s_valid && s_ready && ce`.
  - Pop only on the IDLE→REQ transition.
  - Pointers wrap modulo DEPTH; count is `clog2(DEPTH)+1` bits.
  - No push when full, so simultaneous push+pop at full cannot occur.
  - Push+pop at the same time on a non-full FIFO keeps the count unchanged.
- **FSM states:** IDLE, REQ, WAIT_HI, WAIT_LO, OUT.
  - IDLE: if FIFO non-empty and `!i_run_busy`, pop the head into the `o_run_input_a_0` register, then go to REQ.
  - REQ: `o_run_req`=1 for exactly this one cycle; go to WAIT_HI.
  - WAIT_HI: when `i_run_busy`=1, go to WAIT_LO.
  - WAIT_LO: when `i_run_busy`=0, register `i_run_return` into `m_data`, set `m_valid`, go to OUT.
  - OUT: hold `m_valid`/`m_data` until `m_ready`; then clear `m_valid` and go to IDLE.
- `o_run_input_a_0` stays stable from REQ until the next pop.
- `i_run_return` is sampled only on the busy falling edge; the adder updates its return one cycle before dropping busy.
- Outputs are registered except `s_ready` and `o_idle`.
- **Reset values:**
  - `o_run_req`=0, `m_valid`=0, `m_data`=0, `o_run_input_a_0`=0, `o_err`=0.
  - FIFO empty (`s_ready`=1), FSM in IDLE, `o_idle`=1.
- **Reset mid-transaction:** in-flight sample and FIFO contents are discarded. If the adder is still busy, IDLE waits for `!i_run_busy` before issuing a new request.

## Timing
- Each pop→REQ edge, REQ→WAIT_HI and IDLE decision costs one cycle; `o_run_req` rises one cycle after the IDLE decision.
- The adder raises busy in the cycle after it samples req. With the `addfloat` schedule (phases 0,2, six steps in phase 4, then 3 and 6), busy is high for 10 cycles.
- `m_valid` rises 1 cycle after busy falls.
- Operand-to-result latency, empty pipe, `m_ready` held high: 1 (IDLE) + 1 (REQ) + 10 (busy) + 1 = 13 cycles from the first cycle the operand is in the FIFO.
- Throughput: one result per busy period plus 4 cycles; no overlap.
- While `ce`=0, state, counters and outputs freeze; `o_run_req` stays at its held value (the adder is gated by the same `ce`).

## Configuration
- **`ADDFLOAT_SEQ_TIMEOUT_EN` defined:**
  - A counter clears on entry to WAIT_HI and increments each `ce` cycle in WAIT_HI/WAIT_LO.
  - On reaching TIMEOUT: set `o_err` (sticky until reset), drop the sample (no `m_valid`), return to IDLE.
- **Undefined:** no counter; the FSM waits indefinitely and `o_err` is tied 0.

## Structure
- **Package `addfloat_seq_pkg`:**
  - FSM state enum (3-bit encoding).
  - Data width constant 32.
  - Adder input constant `32'h3fa66666` (1.3f), for benches.
- **Sub-module `addfloat_seq_fifo`:** synchronous FIFO parameterised by DEPTH and width, with full/empty/count outputs. The FSM stays in the top level.

## Test plan
- Single operand `0x3f800000` (1.0), `m_ready`=1, real `addfloat` model → `m_data`=`0x40133333` (2.3), 13 cycles after push, exactly one `o_run_req` pulse.
- Burst of 4 pushes: `0x3f800000`, `0x40000000`, `0x00000000`, `0xbfa66666` → results in order `0x40133333`, `0x40533333`, `0x3fa66666`, `0x00000000`. `s_ready` drops after the 4th push when DEPTH=4 and the first is not yet popped.
- `m_ready` held low 20 cycles in OUT → `m_data` stable, no new `o_run_req`, FIFO keeps accepting until full.
- `ce` toggled 1/0 every cycle during a transaction → same results, latency doubled to 26 cycles.
- With `ADDFLOAT_SEQ_TIMEOUT_EN`, TIMEOUT=8, busy held low forever → `o_err`=1 at cycle 8 of WAIT_HI, no `m_valid`, FSM back in IDLE.
- `reset` asserted in WAIT_LO with 2 entries queued → next cycle `o_idle`=1, `m_valid`=0. No req is issued while the stale busy remains high.
